// File: rtl/fmap_pkg.sv
// -----------------------------------------------------------------------------
// fmap_pkg
// Shared definitions for the feature-map buffer responder: the read-latency
// ceiling, an address-width helper and the clear-engine state encoding.
// -----------------------------------------------------------------------------
package fmap_pkg;

  // Deepest read pipeline the responder supports.
  localparam int READ_LAT_MAX = 4;

  // Address bits needed to index 'depth' entries (never less than one bit).
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Zero-fill engine: idle, sweeping the buffer, one-cycle completion pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage : fmap_pkg

// File: rtl/fmap_bram_responder_if.sv
// -----------------------------------------------------------------------------
// fmap_bram_responder_if
// Feature-map buffer bus between the engines (master) and the buffer
// (slave).
//   Port A : r_en, r_addr            -> r_q, r_valid
//   Port B : w_en, w_we, w_addr, w_d -> wr_drop
//   Clear  : clr_start               -> clr_busy, clr_done
//   Status : err_oob (address >= DEPTH on either port)
// -----------------------------------------------------------------------------
interface fmap_bram_responder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);

  logic                         r_en;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic signed [DATA_WIDTH-1:0] r_q;
  logic                         r_valid;

  logic                         w_en;
  logic                         w_we;
  logic [ADDR_WIDTH-1:0]        w_addr;
  logic signed [DATA_WIDTH-1:0] w_d;

  logic                         clr_start;
  logic                         clr_busy;
  logic                         clr_done;
  logic                         wr_drop;
  logic                         err_oob;

  modport master (
    output r_en, r_addr, w_en, w_we, w_addr, w_d, clr_start,
    input  r_q, r_valid, clr_busy, clr_done, wr_drop, err_oob
  );

  modport slave (
    input  r_en, r_addr, w_en, w_we, w_addr, w_d, clr_start,
    output r_q, r_valid, clr_busy, clr_done, wr_drop, err_oob
  );

endinterface : fmap_bram_responder_if

// File: rtl/fmap_rd_delay.sv
// -----------------------------------------------------------------------------
// fmap_rd_delay
// Fixed-latency valid+data delay line for the read response path.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (clears valid bits only)
//   i_valid : response issued this cycle
//   i_data  : data sampled this cycle
//   o_valid : i_valid delayed by LAT cycles
//   o_data  : i_data delayed by LAT cycles
// -----------------------------------------------------------------------------
module fmap_rd_delay #(
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [LAT-1:0]   r_valid;
  logic [WIDTH-1:0] r_data [LAT];

  // NOTE: sequential state uses non-blocking (<=) so every stage samples the
  // pre-edge value of its predecessor; blocking here would collapse the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // NOTE: data/storage arrays carry no reset; their contents only matter when
  // qualified by a reset-cleared valid, and leaving them unreset lets them map
  // onto plain registers or RAM.
  always_ff @(posedge clk) begin
    r_data[0] <= i_data;
    for (int i = 1; i < LAT; i++) begin
      r_data[i] <= r_data[i-1];
    end
  end

  assign o_valid = r_valid[LAT-1];
  assign o_data  = r_data[LAT-1];

endmodule : fmap_rd_delay

// File: rtl/fmap_bram_responder.sv
// -----------------------------------------------------------------------------
// fmap_bram_responder
// Feature-map buffer: answers port-A reads after READ_LAT cycles, commits
// port-B writes, zero-fills the whole buffer on request and flags
// out-of-range or dropped accesses.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : fmap_bram_responder_if.slave (read, write, clear, status)
// DEPTH must be >= 2; READ_LAT outside 1..READ_LAT_MAX is clamped.
// -----------------------------------------------------------------------------
module fmap_bram_responder
  import fmap_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int READ_LAT   = 1,
  parameter int ADDR_WIDTH = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fmap_bram_responder_if.slave  bus
);

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0]        addr_t;

  localparam int LAT = (READ_LAT < 1)            ? 1 :
                       (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

  // One spare bit so DEPTH itself is representable for the range compare.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam addr_t               LAST_ADDR = addr_t'(DEPTH - 1);

  data_t      r_mem [DEPTH];

  clr_state_t r_state;
  clr_state_t w_state_nxt;
  addr_t      r_clr_cnt;
  addr_t      w_clr_cnt_nxt;
  logic       w_clr_busy;
  logic       w_clr_done;
  logic       w_clr_we;

  logic       w_rd_oob;
  logic       w_wr_oob;
  logic       w_wr_req;
  logic       w_wr_commit;
  data_t      w_rd_data;

  logic       w_dly_valid;
  data_t      w_dly_data;
  data_t      r_q_last;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  assign w_rd_oob = ({1'b0, bus.r_addr} >= DEPTH_EXT);
  assign w_wr_oob = ({1'b0, bus.w_addr} >= DEPTH_EXT);
  assign w_wr_req = bus.w_en && bus.w_we;

  // The clear engine owns the write path while busy; out-of-range writes
  // never touch storage.
  assign w_wr_commit = w_wr_req && !w_clr_busy && !w_wr_oob;

  // ---------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_busy    = 1'b0;
    w_clr_done    = 1'b0;
    w_clr_we      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.clr_start) begin
          w_state_nxt   = CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        // clr_start is not looked at here, so a repeat request cannot restart
        // the sweep.
        w_clr_busy = 1'b1;
        w_clr_we   = 1'b1;
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt = DONE;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + addr_t'(1);
        end
      end
      DONE: begin
        w_clr_done  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage: one write per cycle, from either the clear engine or port B.
  // Reads sample combinationally in the issue cycle, so a same-cycle write to
  // the same address is seen only by later reads (read-first).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_commit) begin
      r_mem[bus.w_addr] <= bus.w_d;
    end
  end

  assign w_rd_data = w_rd_oob ? '0 : r_mem[bus.r_addr];

  // ---------------------------------------------------------------------------
  // Read response path
  // ---------------------------------------------------------------------------
  fmap_rd_delay #(
    .WIDTH (DATA_WIDTH),
    .LAT   (LAT)
  ) u_rd_delay (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_valid (bus.r_en),
    .i_data  (w_rd_data),
    .o_valid (w_dly_valid),
    .o_data  (w_dly_data)
  );

  // r_q shows the arriving response in its valid cycle and otherwise holds the
  // last delivered value; the holding register is what reset clears to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_last <= '0;
    end else if (w_dly_valid) begin
      r_q_last <= w_dly_data;
    end
  end

  assign bus.r_valid  = w_dly_valid;
  assign bus.r_q      = w_dly_valid ? w_dly_data : r_q_last;

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign bus.clr_busy = w_clr_busy;
  assign bus.clr_done = w_clr_done;
  assign bus.wr_drop  = w_wr_req && w_clr_busy;
  // One combined pulse even when both ports are out of range together.
  assign bus.err_oob  = (bus.r_en && w_rd_oob) || (w_wr_req && w_wr_oob);

endmodule : fmap_bram_responder

// File: tb/tb_fmap_bram_responder.sv
// -----------------------------------------------------------------------------
// tb_fmap_bram_responder
// Directed bench for fmap_bram_responder. Four instances cover the
// configurations exercised: (DEPTH 64, LAT 1), (72, 3), (48, 1), (64, 2).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_fmap_bram_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fmap_bram_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) if0 ();
  fmap_bram_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(7)) if1 ();
  fmap_bram_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) if2 ();
  fmap_bram_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) if3 ();

  fmap_bram_responder #(.DATA_WIDTH(16), .DEPTH(64), .READ_LAT(1), .ADDR_WIDTH(6))
    u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  fmap_bram_responder #(.DATA_WIDTH(16), .DEPTH(72), .READ_LAT(3), .ADDR_WIDTH(7))
    u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  fmap_bram_responder #(.DATA_WIDTH(16), .DEPTH(48), .READ_LAT(1), .ADDR_WIDTH(6))
    u2 (.clk(clk), .reset_n(reset_n), .bus(if2));
  fmap_bram_responder #(.DATA_WIDTH(16), .DEPTH(64), .READ_LAT(2), .ADDR_WIDTH(6))
    u3 (.clk(clk), .reset_n(reset_n), .bus(if3));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic idle_all();
    if0.r_en = 0; if0.r_addr = '0; if0.w_en = 0; if0.w_we = 0; if0.w_addr = '0; if0.w_d = '0; if0.clr_start = 0;
    if1.r_en = 0; if1.r_addr = '0; if1.w_en = 0; if1.w_we = 0; if1.w_addr = '0; if1.w_d = '0; if1.clr_start = 0;
    if2.r_en = 0; if2.r_addr = '0; if2.w_en = 0; if2.w_we = 0; if2.w_addr = '0; if2.w_d = '0; if2.clr_start = 0;
    if3.r_en = 0; if3.r_addr = '0; if3.w_en = 0; if3.w_we = 0; if3.w_addr = '0; if3.w_d = '0; if3.clr_start = 0;
  endtask

  // One cycle of stimulus on instance u0 and the outputs expected in that
  // same cycle (r_valid/r_q reflect the read issued one cycle earlier).
  typedef struct {
    logic               r_en;
    logic [5:0]         r_addr;
    logic               w_en;
    logic               w_we;
    logic [5:0]         w_addr;
    logic signed [15:0] w_d;
    logic               e_valid;
    logic signed [15:0] e_q;
    logic               e_drop;
    logic               e_oob;
  } vec_t;

  function automatic vec_t mk(input logic re, input int ra, input logic wen, input logic wwe,
                              input int wa, input int wd, input logic ev, input int eq,
                              input logic ed, input logic eo);
    vec_t v;
    v.r_en = re;  v.r_addr = 6'(ra);
    v.w_en = wen; v.w_we = wwe; v.w_addr = 6'(wa); v.w_d = 16'(wd);
    v.e_valid = ev; v.e_q = 16'(eq); v.e_drop = ed; v.e_oob = eo;
    return v;
  endfunction

  vec_t vecs [10];

  int busy_cnt, done_cnt, done_cyc, first_busy, evt_cnt;

  initial begin
    // Table: w_en-only no-op, read-first collision, write-then-read, extremes.
    vecs[0] = mk(0,  0, 1, 1,  3,     -1, 0,     31, 0, 0);
    vecs[1] = mk(0,  0, 1, 0,  3,     55, 0,     31, 0, 0);
    vecs[2] = mk(1,  3, 0, 0,  0,      0, 0,     31, 0, 0);
    vecs[3] = mk(1,  4, 1, 1,  4,     77, 1,     -1, 0, 0);
    vecs[4] = mk(1,  4, 0, 0,  0,      0, 1,    -28, 0, 0);
    vecs[5] = mk(0,  0, 0, 0,  0,      0, 1,     77, 0, 0);
    vecs[6] = mk(0,  0, 1, 1, 63, -32768, 0,     77, 0, 0);
    vecs[7] = mk(1, 63, 0, 0,  0,      0, 0,     77, 0, 0);
    vecs[8] = mk(0,  0, 0, 0,  0,      0, 1, -32768, 0, 0);
    vecs[9] = mk(0,  0, 0, 0,  0,      0, 0, -32768, 0, 0);

    idle_all();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst u0 r_q", if0.r_q, 0);
    check("rst u0 r_valid", if0.r_valid, 0);
    check("rst u0 clr_busy", if0.clr_busy, 0);
    check("rst u0 clr_done", if0.clr_done, 0);
    check("rst u0 wr_drop", if0.wr_drop, 0);
    check("rst u0 err_oob", if0.err_oob, 0);
    check("rst u1 r_valid", if1.r_valid, 0);
    check("rst u3 r_q", if3.r_q, 0);
    reset_n = 1'b1;

    // ---------------- back-to-back reads, LAT 1 ----------------
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); idle_all();
      if0.w_en = 1; if0.w_we = 1; if0.w_addr = 6'(i); if0.w_d = 16'(i - 32);
    end
    @(negedge clk); idle_all();
    for (int k = 0; k < 67; k++) begin
      @(negedge clk); idle_all();
      if (k < 64) begin if0.r_en = 1; if0.r_addr = 6'(k); end
      #1;
      if (k == 0) begin
        check("b2b valid before first", if0.r_valid, 0);
      end else if (k <= 64) begin
        check($sformatf("b2b valid %0d", k - 1), if0.r_valid, 1);
        check($sformatf("b2b r_q %0d", k - 1), if0.r_q, k - 33);
      end else begin
        check($sformatf("b2b tail valid %0d", k), if0.r_valid, 0);
        check($sformatf("b2b tail hold %0d", k), if0.r_q, 31);
      end
    end

    // ---------------- table vectors on u0 ----------------
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); idle_all();
      if0.r_en = vecs[i].r_en; if0.r_addr = vecs[i].r_addr;
      if0.w_en = vecs[i].w_en; if0.w_we = vecs[i].w_we;
      if0.w_addr = vecs[i].w_addr; if0.w_d = vecs[i].w_d;
      #1;
      check($sformatf("vec%0d r_valid", i), if0.r_valid, vecs[i].e_valid);
      check($sformatf("vec%0d r_q", i), if0.r_q, vecs[i].e_q);
      check($sformatf("vec%0d wr_drop", i), if0.wr_drop, vecs[i].e_drop);
      check($sformatf("vec%0d err_oob", i), if0.err_oob, vecs[i].e_oob);
    end

    // ---------------- collision, LAT 3, DEPTH 72 ----------------
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_all();
      if1.w_en = 1; if1.w_we = 1;
      if1.w_addr = (i == 0) ? 7'd5 : (i == 1) ? 7'd8 : 7'd16;
      if1.w_d    = (i == 0) ? -16'sd7 : (i == 1) ? 16'sd8 : 16'sd16;
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); idle_all();
      if (c == 0) begin
        if1.r_en = 1; if1.r_addr = 7'd5;
        if1.w_en = 1; if1.w_we = 1; if1.w_addr = 7'd5; if1.w_d = 16'sd100;
      end
      if (c == 1) begin if1.r_en = 1; if1.r_addr = 7'd5; end
      #1;
      if (c == 0) check("coll err_oob", if1.err_oob, 0);
      if (c <= 2) check($sformatf("coll valid early c%0d", c), if1.r_valid, 0);
      if (c == 3) begin check("coll valid t+3", if1.r_valid, 1); check("coll read-first", if1.r_q, -7); end
      if (c == 4) begin check("coll valid t+4", if1.r_valid, 1); check("coll new data", if1.r_q, 100); end
      if (c == 5) begin check("coll valid end", if1.r_valid, 0); check("coll hold", if1.r_q, 100); end
    end

    // ---------------- out-of-range accesses, DEPTH 72 ----------------
    for (int c = 0; c < 13; c++) begin
      @(negedge clk); idle_all();
      case (c)
        0: begin
          if1.r_en = 1; if1.r_addr = 7'd72;
          if1.w_en = 1; if1.w_we = 1; if1.w_addr = 7'd80; if1.w_d = 16'sd123;
        end
        4:  begin if1.r_en = 1; if1.r_addr = 7'd5; end
        5:  begin if1.r_en = 1; if1.r_addr = 7'd8; end
        6:  begin if1.r_en = 1; if1.r_addr = 7'd16; end
        10: begin if1.w_en = 1; if1.w_we = 1; if1.w_addr = 7'd72; if1.w_d = 16'sd1; end
        11: begin if1.w_en = 1; if1.w_we = 0; if1.w_addr = 7'd127; end
        12: begin if1.r_en = 1; if1.r_addr = 7'd71; end
        default: ;
      endcase
      #1;
      case (c)
        0: check("oob both pulse", if1.err_oob, 1);
        1: check("oob pulse ends", if1.err_oob, 0);
        2: begin check("oob valid early", if1.r_valid, 0); check("oob hold", if1.r_q, 100); end
        3: begin check("oob valid t+3", if1.r_valid, 1); check("oob r_q zero", if1.r_q, 0); end
        7: check("oob mem5 kept", if1.r_q, 100);
        8: check("oob mem8 kept", if1.r_q, 8);
        9: check("oob mem16 kept", if1.r_q, 16);
        10: check("oob write pulse", if1.err_oob, 1);
        11: check("oob w_en only quiet", if1.err_oob, 0);
        12: check("read addr 71 in range", if1.err_oob, 0);
        default: ;
      endcase
    end

    // ---------------- clear engine, DEPTH 48 ----------------
    for (int i = 0; i < 48; i++) begin
      @(negedge clk); idle_all();
      if2.w_en = 1; if2.w_we = 1; if2.w_addr = 6'(i); if2.w_d = 16'sh07FF;
    end
    @(negedge clk); idle_all();
    if2.clr_start = 1;
    if2.w_en = 1; if2.w_we = 1; if2.w_addr = 6'd47; if2.w_d = 16'sd5;
    #1;
    check("clr start+write no drop", if2.wr_drop, 0);
    check("clr busy not yet", if2.clr_busy, 0);
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; first_busy = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk); idle_all();
      if (c == 1)  begin if2.r_en = 1; if2.r_addr = 6'd40; end
      if (c == 3)  begin if2.r_en = 1; if2.r_addr = 6'd0; end
      if (c == 5)  if2.clr_start = 1;
      if (c == 30) begin if2.w_en = 1; if2.w_we = 1; if2.w_addr = 6'd10; if2.w_d = 16'sd9; end
      #1;
      if (if2.clr_busy) begin busy_cnt++; if (first_busy < 0) first_busy = c; end
      if (if2.clr_done) begin done_cnt++; done_cyc = c; end
      if (c == 2)  check("clr read uncleared row", if2.r_q, 2047);
      if (c == 4)  check("clr read cleared row", if2.r_q, 0);
      if (c == 30) begin check("clr write dropped", if2.wr_drop, 1); check("clr drop no oob", if2.err_oob, 0); end
      if (c == 31) check("clr drop pulse ends", if2.wr_drop, 0);
    end
    check("clr busy cycles", busy_cnt, 48);
    check("clr first busy cycle", first_busy, 1);
    check("clr done pulses", done_cnt, 1);
    check("clr done cycle", done_cyc, 49);
    for (int k = 0; k <= 48; k++) begin
      @(negedge clk); idle_all();
      if (k < 48) begin if2.r_en = 1; if2.r_addr = 6'(k); end
      #1;
      if (k >= 1) check($sformatf("clr readback %0d", k - 1), if2.r_q, 0);
    end

    // ---------------- reset mid-clear, LAT 2 ----------------
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); idle_all();
      if3.w_en = 1; if3.w_we = 1; if3.w_addr = 6'(i); if3.w_d = 16'(1000 + i);
    end
    @(negedge clk); idle_all();
    if3.clr_start = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); idle_all();
      if (c == 19) begin if3.r_en = 1; if3.r_addr = 6'd40; end
      if (c == 20) begin if3.r_en = 1; if3.r_addr = 6'd41; end
      #1;
      if (c == 20) check("rstclr busy before reset", if3.clr_busy, 1);
    end
    @(negedge clk); idle_all();
    reset_n = 1'b0;
    #1;
    check("rstclr r_q", if3.r_q, 0);
    check("rstclr r_valid", if3.r_valid, 0);
    check("rstclr clr_busy", if3.clr_busy, 0);
    check("rstclr clr_done", if3.clr_done, 0);
    check("rstclr wr_drop", if3.wr_drop, 0);
    check("rstclr err_oob", if3.err_oob, 0);
    evt_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); idle_all();
      if (c == 2) reset_n = 1'b1;
      #1;
      if (if3.r_valid || if3.clr_done || if3.clr_busy) evt_cnt++;
    end
    check("rstclr no late events", evt_cnt, 0);
    for (int k = 0; k < 66; k++) begin
      @(negedge clk); idle_all();
      if (k < 64) begin if3.r_en = 1; if3.r_addr = 6'(k); end
      #1;
      if (k >= 2) check($sformatf("rstclr mem %0d", k - 2), if3.r_q, (k - 2 < 20) ? 0 : 1000 + k - 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fmap_bram_responder
